sc_displaytimer_tickgen: RTL
============================

Name: sc_displaytimer_tickgen

Overview:
Upstream pacing stage for the display-timer counter.
- Divides the 50 MHz clock into a one-cycle, active-low upcount strobe that drives the counter's upcount_InLow input.
- Start/pause/stop control comes from the game FSM through a small control state machine.
- Tracks elapsed ticks against a limit and flags round timeout.

Parameters:
PRESCALE_WIDTH, 26, width of prescaler register
PRESCALE_DIV, 50000000, clock cycles per tick (1 Hz at 50 MHz); legal range 2..2^PRESCALE_WIDTH
LIMIT_WIDTH, 8, width of internal tick count
LIMIT_TICKS, 60, ticks per round before expiry; legal range 1..2^LIMIT_WIDTH-1

Ports:
SC_DISPLAYTIMER_COUNTER_CLOCK_50  in  1  system clock, 50 MHz
SC_DISPLAYTIMER_COUNTER_RESET_InHigh  in  1  asynchronous, active-high reset
SC_DISPLAYTIMER_TICKGEN_start_InHigh  in  1  one-cycle request: begin or restart round
SC_DISPLAYTIMER_TICKGEN_pause_InHigh  in  1  level: freeze timing while high
SC_DISPLAYTIMER_TICKGEN_stop_InHigh  in  1  one-cycle request: abort to idle
SC_DISPLAYTIMER_TICKGEN_upcount_OutLow  out  1  registered strobe, low for one cycle per tick
SC_DISPLAYTIMER_TICKGEN_running_OutHigh  out  1  high in RUN
SC_DISPLAYTIMER_TICKGEN_expired_OutHigh  out  1  high in EXPIRED
SC_DISPLAYTIMER_TICKGEN_tickcount_OutBUS  out  LIMIT_WIDTH  ticks issued this round

Behaviour:
- Reset, asynchronous, to IDLE.
  - Prescaler = 0, tickcount = 0.
  - upcount_OutLow = 1, running = 0, expired = 0.
- FSM states: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- Input priority each cycle: stop > start > pause > terminal count.
- IDLE
  - Prescaler and tickcount held at 0.
  - start -> RUN. stop and pause are ignored.
- RUN
  - Prescaler increments each cycle.
  - Terminal count is prescaler == PRESCALE_DIV-1. On terminal count:
    - prescaler <= 0 and tickcount <= tickcount+1.
    - upcount_OutLow is low in the following cycle only.
  - Terminal count with tickcount+1 == LIMIT_TICKS: the final strobe is still issued, then -> EXPIRED.
  - pause -> PAUSE. Prescaler holds; no strobe this cycle, even if at terminal count.
  - start (restart): prescaler <= 0, tickcount <= 0, stay in RUN, no strobe.
  - stop -> IDLE. Any pending strobe is cancelled.
- PAUSE
  - Prescaler and tickcount hold.
  - pause low -> RUN; counting resumes from the held value. A held terminal count fires on the first RUN cycle.
  - start -> RUN with restart clears. stop -> IDLE.
- EXPIRED
  - No strobes. tickcount holds LIMIT_TICKS.
  - start -> RUN with clears. stop -> IDLE.
- Strobe spacing in continuous RUN is exactly PRESCALE_DIV cycles.
- First strobe is PRESCALE_DIV cycles after the start cycle.
- Strobe is never asserted on consecutive cycles.
- Restart does not clear the downstream counter; top level resets it via the shared reset.
- Reset asserted mid-round takes effect immediately, independent of clock.

Optional Feature:
SC_DISPLAYTIMER_TICKGEN_FASTSIM_EN
- Defined: effective divide is forced to 4, regardless of PRESCALE_DIV, for simulation and short hardware bring-up.
- Undefined: PRESCALE_DIV is used as given.
- All other behaviour is identical in both cases.

Decomposition:
- Shared package (or common include):
  - FSM state encodings: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, EXPIRED=2'b11.
  - Default PRESCALE_DIV and LIMIT_TICKS constants.
- Sub-module sc_displaytimer_prescaler:
  - Modulo-N counter with clear, enable and registered terminal-count output.
  - FSM drives its enable and clear.

Test Plan:
- PRESCALE_DIV=4, LIMIT_TICKS=3. Reset, then start pulse at cycle 0 -> upcount_OutLow low at cycles 4, 8, 12 only; tickcount 1, 2, 3; expired=1 from cycle 13; running=0.
- Pause held cycles 2..9 after start -> no strobe during pause; first strobe at cycle 12; spacing 4 thereafter.
- stop asserted in the same cycle the prescaler hits terminal count -> no strobe; IDLE next cycle; tickcount=0.
- start asserted together with pause during RUN -> restart wins; prescaler=0, tickcount=0, state RUN, next strobe 4 cycles later.
- Asynchronous reset asserted mid-cycle during RUN with tickcount=2 -> all outputs at reset values immediately; next start begins a fresh round.
- FASTSIM_EN defined, PRESCALE_DIV=50000000 -> strobes every 4 cycles.

Source files
------------

// File: rtl/sc_displaytimer_tickgen_pkg.sv
// Shared types and defaults for the display-timer tick generator.
// Holds FSM encodings and default divide/limit constants.
package sc_displaytimer_tickgen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } tickgen_state_t;

  localparam int DEF_PRESCALE_DIV = 50000000;
  localparam int DEF_LIMIT_TICKS  = 60;
  localparam int FASTSIM_DIV      = 4;

endpackage

// File: rtl/sc_displaytimer_prescaler.sv
// Modulo-DIV counter with clear/enable and a registered terminal count.
// Ports: clock, async high reset, clr/en in, tc_OutHigh (count == DIV-1).
module sc_displaytimer_prescaler #(
  parameter int WIDTH = 26,
  parameter int DIV   = 50000000
) (
  input  logic SC_DISPLAYTIMER_COUNTER_CLOCK_50,
  input  logic SC_DISPLAYTIMER_COUNTER_RESET_InHigh,
  input  logic clr_InHigh,
  input  logic en_InHigh,
  output logic tc_OutHigh
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(DIV - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt_q;
    if (clr_InHigh)
      cnt_n = '0;
    else if (en_InHigh)
      cnt_n = tc_OutHigh ? '0 : cnt_q + WIDTH'(1);
  end

  // tc tracks the count register, so it flags the
  // current value without adding latency.
  always_ff @(posedge SC_DISPLAYTIMER_COUNTER_CLOCK_50
              or posedge SC_DISPLAYTIMER_COUNTER_RESET_InHigh) begin
    if (SC_DISPLAYTIMER_COUNTER_RESET_InHigh) begin
      cnt_q      <= '0;
      tc_OutHigh <= 1'b0;
    end else begin
      cnt_q      <= cnt_n;
      tc_OutHigh <= (cnt_n == TC_VAL);
    end
  end

endmodule

// File: rtl/sc_displaytimer_tickgen.sv
// Display-timer pacing stage: active-low tick strobe, run/pause/stop FSM,
// round tick count and timeout. Macro SC_DISPLAYTIMER_TICKGEN_FASTSIM_EN
// forces a divide of 4. Ports: clock, async high reset, start/pause/stop
// in; upcount_OutLow, running, expired, tickcount out (all registered).
module sc_displaytimer_tickgen
  import sc_displaytimer_tickgen_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 26,
  parameter int PRESCALE_DIV   = DEF_PRESCALE_DIV,
  parameter int LIMIT_WIDTH    = 8,
  parameter int LIMIT_TICKS    = DEF_LIMIT_TICKS
) (
  input  logic                   SC_DISPLAYTIMER_COUNTER_CLOCK_50,
  input  logic                   SC_DISPLAYTIMER_COUNTER_RESET_InHigh,
  input  logic                   SC_DISPLAYTIMER_TICKGEN_start_InHigh,
  input  logic                   SC_DISPLAYTIMER_TICKGEN_pause_InHigh,
  input  logic                   SC_DISPLAYTIMER_TICKGEN_stop_InHigh,
  output logic                   SC_DISPLAYTIMER_TICKGEN_upcount_OutLow,
  output logic                   SC_DISPLAYTIMER_TICKGEN_running_OutHigh,
  output logic                   SC_DISPLAYTIMER_TICKGEN_expired_OutHigh,
  output logic [LIMIT_WIDTH-1:0] SC_DISPLAYTIMER_TICKGEN_tickcount_OutBUS
);

`ifdef SC_DISPLAYTIMER_TICKGEN_FASTSIM_EN
  localparam int EFF_DIV = FASTSIM_DIV;
`else
  localparam int EFF_DIV = PRESCALE_DIV;
`endif

  localparam logic [LIMIT_WIDTH-1:0] LIMIT_VAL =
    LIMIT_WIDTH'(LIMIT_TICKS);

  tickgen_state_t state_q, state_n;
  logic [LIMIT_WIDTH-1:0] tick_q, tick_n;
  logic up_q, up_n;
  logic run_q, exp_q;
  logic pre_clr, pre_en, pre_tc;
  logic step;

  wire start = SC_DISPLAYTIMER_TICKGEN_start_InHigh;
  wire pause = SC_DISPLAYTIMER_TICKGEN_pause_InHigh;
  wire stop  = SC_DISPLAYTIMER_TICKGEN_stop_InHigh;

  sc_displaytimer_prescaler #(
    .WIDTH (PRESCALE_WIDTH),
    .DIV   (EFF_DIV)
  ) u_prescaler (
    .SC_DISPLAYTIMER_COUNTER_CLOCK_50     (SC_DISPLAYTIMER_COUNTER_CLOCK_50),
    .SC_DISPLAYTIMER_COUNTER_RESET_InHigh (SC_DISPLAYTIMER_COUNTER_RESET_InHigh),
    .clr_InHigh                           (pre_clr),
    .en_InHigh                            (pre_en),
    .tc_OutHigh                           (pre_tc)
  );

  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    up_n    = 1'b1;
    pre_clr = 1'b0;
    pre_en  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        pre_clr = 1'b1;
        tick_n  = '0;
        if (start) state_n = RUN;
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          pre_clr = 1'b1;
          tick_n  = '0;
        end else if (start) begin
          pre_clr = 1'b1;
          tick_n  = '0;
        end else if (pause) begin
          state_n = PAUSE;
        end else if (tick_q == LIMIT_VAL) begin
          // final strobe went out last cycle
          state_n = EXPIRED;
          pre_clr = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_n = IDLE;
          pre_clr = 1'b1;
          tick_n  = '0;
        end else if (start) begin
          state_n = RUN;
          pre_clr = 1'b1;
          tick_n  = '0;
        end else if (!pause) begin
          // resume counts this cycle, so a held
          // terminal count strobes on the first RUN cycle
          state_n = RUN;
          step    = 1'b1;
        end
      end
      EXPIRED: begin
        pre_clr = 1'b1;
        if (stop) begin
          state_n = IDLE;
          tick_n  = '0;
        end else if (start) begin
          state_n = RUN;
          tick_n  = '0;
        end
      end
    endcase
    if (step) begin
      pre_en = 1'b1;
      if (pre_tc) begin
        tick_n = tick_q + LIMIT_WIDTH'(1);
        up_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge SC_DISPLAYTIMER_COUNTER_CLOCK_50
              or posedge SC_DISPLAYTIMER_COUNTER_RESET_InHigh) begin
    if (SC_DISPLAYTIMER_COUNTER_RESET_InHigh) begin
      state_q <= IDLE;
      tick_q  <= '0;
      up_q    <= 1'b1;
      run_q   <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      up_q    <= up_n;
      run_q   <= (state_n == RUN);
      exp_q   <= (state_n == EXPIRED);
    end
  end

  assign SC_DISPLAYTIMER_TICKGEN_upcount_OutLow   = up_q;
  assign SC_DISPLAYTIMER_TICKGEN_running_OutHigh  = run_q;
  assign SC_DISPLAYTIMER_TICKGEN_expired_OutHigh  = exp_q;
  assign SC_DISPLAYTIMER_TICKGEN_tickcount_OutBUS = tick_q;

endmodule
